// File: rtl/l2_ifill_adapter.sv
// Icache line-fill to L2 acquire/grant adapter: one get-block acquire per line, grant beats gathered in any order.
// Request-to-acquire 1 cycle, last-beat-to-response 1 cycle; grants are always sunk while a refill is open.
module l2_ifill_adapter #(
  parameter int BEATS   = 4,
  parameter int BEAT_W  = 128,
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      flush_i,
  input  logic                      ifill_req_valid_i,
  input  logic [ADDR_W-1:0]         ifill_req_paddr_i,
  output logic                      ifill_req_ready_o,
  output logic                      ifill_resp_valid_o,
  output logic [BEATS*BEAT_W-1:0]   ifill_resp_data_o,
  output logic [ADDR_W-1:0]         ifill_resp_paddr_o,
  output logic                      ifill_resp_err_o,
  output logic                      acq_valid_o,
  input  logic                      acq_ready_i,
  output logic [ADDR_W-1:0]         acq_addr_block_o,
  output logic                      acq_xact_id_o,
  output logic                      acq_builtin_o,
  output logic [2:0]                acq_a_type_o,
  output logic [16:0]               acq_union_o,
  input  logic                      gnt_valid_i,
  input  logic [BEAT_W-1:0]         gnt_data_i,
  input  logic [$clog2(BEATS)-1:0]  gnt_beat_i,
  input  logic                      gnt_xact_id_i,
  output logic                      gnt_ready_o
);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Abort fires on the idle cycle whose increment would reach TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_GNT, S_RESP, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      id_q, id_d;
  logic                      kill_q, kill_d;
  logic                      err_q, err_d;
  logic [BEATS-1:0]          mask_q, mask_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEATS*BEAT_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]         paddr_q, paddr_d;

  logic             in_gnt, req_fire, acq_fire, beat_acc, line_full, timed_out;
  logic [BEATS-1:0] beat_sel, mask_upd;

  always_comb begin
    in_gnt    = (state_q == S_GNT) || (state_q == S_DRAIN);
    req_fire  = (state_q == S_IDLE) && ifill_req_valid_i && !flush_i;
    acq_fire  = (state_q == S_ACQ) && acq_ready_i;
    beat_acc  = in_gnt && gnt_valid_i && (gnt_xact_id_i == id_q);
    beat_sel  = beat_acc ? (BEATS'(1) << gnt_beat_i) : '0;
    mask_upd  = mask_q | beat_sel;
    line_full = &mask_upd;
    timed_out = in_gnt && !beat_acc && (cnt_q >= CNT_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_fire) state_d = S_ACQ;
      S_ACQ:   if (acq_ready_i) state_d = (kill_q || flush_i) ? S_DRAIN : S_GNT;
      S_GNT: begin
        if (flush_i)                     state_d = S_DRAIN;
        else if (line_full || timed_out) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (line_full || timed_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    id_d    = id_q;
    kill_d  = kill_q;
    err_d   = err_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    paddr_d = paddr_q;
    if (req_fire) begin
      paddr_d = ifill_req_paddr_i;
      kill_d  = 1'b0;
    end
    if ((state_q == S_ACQ) && flush_i) kill_d = 1'b1;
    if (acq_fire) begin
      mask_d = '0;
      cnt_d  = '0;
    end
    if (in_gnt) cnt_d = beat_acc ? '0 : cnt_q + 1'b1;
    if (beat_acc) begin
      mask_d = mask_upd;
      line_d[int'(gnt_beat_i)*BEAT_W +: BEAT_W] = gnt_data_i;
    end
    if ((state_q == S_GNT) && (state_d == S_RESP)) err_d = !line_full;
    // Every way out of a transaction flips the id so stragglers from it are discarded.
    if ((state_q != S_IDLE) && (state_d == S_IDLE)) id_d = !id_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      id_q    <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      paddr_q <= '0;
    end else begin
      id_q    <= id_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      paddr_q <= paddr_d;
    end
  end

  always_comb begin
    ifill_req_ready_o  = 1'b0;
    ifill_resp_valid_o = 1'b0;
    ifill_resp_data_o  = '0;
    ifill_resp_paddr_o = '0;
    ifill_resp_err_o   = 1'b0;
    acq_valid_o        = 1'b0;
    acq_addr_block_o   = '0;
    acq_xact_id_o      = 1'b0;
    acq_builtin_o      = 1'b0;
    acq_a_type_o       = 3'b000;
    acq_union_o        = 17'b0;
    gnt_ready_o        = 1'b0;
    if (rstn_i) begin
      ifill_req_ready_o  = (state_q == S_IDLE);
      ifill_resp_valid_o = (state_q == S_RESP) && !flush_i;
      ifill_resp_data_o  = line_q;
      ifill_resp_paddr_o = paddr_q;
      ifill_resp_err_o   = err_q;
      acq_valid_o        = (state_q == S_ACQ);
      acq_addr_block_o   = paddr_q;
      acq_xact_id_o      = id_q;
      acq_builtin_o      = 1'b1;
      acq_a_type_o       = 3'b001;
      acq_union_o        = 17'b00000000111000001;
      gnt_ready_o        = in_gnt;
    end
  end

endmodule

// File: tb/tb_l2_ifill_adapter.sv
// Directed and randomized refill transactions checked against a transaction-level model of the adapter.
module tb_l2_ifill_adapter;
  localparam int BEATS   = 4;
  localparam int BEAT_W  = 128;
  localparam int ADDR_W  = 26;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, flush, req_vld, req_rdy, resp_vld, resp_err;
  logic [ADDR_W-1:0]  req_pa, resp_pa, acq_addr;
  logic [511:0]       resp_dat;
  logic               acq_vld, acq_rdy, acq_id, acq_bi;
  logic [2:0]         acq_type;
  logic [16:0]        acq_un;
  logic               gnt_vld, gnt_id, gnt_rdy;
  logic [BEAT_W-1:0]  gnt_dat;
  logic [1:0]         gnt_beat;

  l2_ifill_adapter #(.BEATS(BEATS), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .ifill_req_valid_i(req_vld), .ifill_req_paddr_i(req_pa), .ifill_req_ready_o(req_rdy),
    .ifill_resp_valid_o(resp_vld), .ifill_resp_data_o(resp_dat), .ifill_resp_paddr_o(resp_pa),
    .ifill_resp_err_o(resp_err),
    .acq_valid_o(acq_vld), .acq_ready_i(acq_rdy), .acq_addr_block_o(acq_addr), .acq_xact_id_o(acq_id),
    .acq_builtin_o(acq_bi), .acq_a_type_o(acq_type), .acq_union_o(acq_un),
    .gnt_valid_i(gnt_vld), .gnt_data_i(gnt_dat), .gnt_beat_i(gnt_beat), .gnt_xact_id_i(gnt_id),
    .gnt_ready_o(gnt_rdy)
  );

  typedef struct {
    bit               vld;
    int               idx;
    logic [BEAT_W-1:0] dat;
    bit               good;
    bit               fl;
  } ent_t;

  ent_t              plan[$];
  logic [BEAT_W-1:0] exp_line [4];
  logic              model_id;
  int                total = 0;
  int                bad = 0;
  int                cyc_no = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic idle_in();
    req_vld  = 1'b0;
    flush    = 1'b0;
    acq_rdy  = 1'b0;
    gnt_vld  = 1'b0;
    gnt_beat = 2'd0;
    gnt_dat  = '0;
    gnt_id   = 1'b0;
  endtask

  function automatic logic [BEAT_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add(input bit vld, input int idx, input logic [BEAT_W-1:0] dat, input bit good, input bit fl);
    ent_t e;
    e.vld = vld; e.idx = idx; e.dat = dat; e.good = good; e.fl = fl;
    plan.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dat"}, resp_dat, '0);
    chk({tag, "_ctl"}, {req_rdy, resp_vld, resp_pa, resp_err, acq_vld, acq_addr, acq_id,
                        acq_bi, acq_type, acq_un, gnt_rdy}, '0);
  endtask

  // One refill: request, acquire after acq_wait stalled cycles, then the grant plan,
  // then the response (or drain exit) whose timing follows from the plan.
  task automatic xact(input logic [ADDR_W-1:0] pa, input int acq_wait, input int flush_acq, input bit flush_resp);
    int         last_clear;
    bit         killed;
    logic [3:0] covered;
    idle_in();
    req_vld = 1'b1;
    req_pa  = pa;
    mid();
    chk("req_ready_idle", req_rdy, 1'b1);
    chk("acq_valid_idle", acq_vld, 1'b0);
    nxt();
    req_vld = 1'b0;
    req_pa  = ADDR_W'($urandom);
    killed  = 1'b0;
    last_clear = cyc_no;
    for (int i = 0; i <= acq_wait; i++) begin
      acq_rdy = (i == acq_wait);
      flush   = (i == flush_acq);
      mid();
      chk("acq_valid", acq_vld, 1'b1);
      chk("acq_addr", acq_addr, pa);
      chk("acq_id", acq_id, model_id);
      chk("acq_consts", {acq_bi, acq_type, acq_un}, {1'b1, 3'b001, 17'b00000000111000001});
      chk("acq_req_ready", req_rdy, 1'b0);
      chk("acq_gnt_ready", gnt_rdy, 1'b0);
      if (i == flush_acq) killed = 1'b1;
      if (i == acq_wait) last_clear = cyc_no;
      nxt();
    end
    idle_in();
    covered = 4'h0;
    foreach (plan[k]) begin
      flush    = plan[k].fl;
      gnt_vld  = plan[k].vld;
      gnt_beat = 2'(plan[k].idx);
      gnt_dat  = plan[k].dat;
      gnt_id   = plan[k].good ? model_id : !model_id;
      mid();
      chk("gnt_ready", gnt_rdy, 1'b1);
      chk("gnt_no_resp", resp_vld, 1'b0);
      chk("gnt_no_acq", acq_vld, 1'b0);
      if (plan[k].vld && plan[k].good) begin
        exp_line[plan[k].idx] = plan[k].dat;
        covered[plan[k].idx]  = 1'b1;
        last_clear = cyc_no;
      end
      if (plan[k].fl) killed = 1'b1;
      nxt();
    end
    idle_in();
    if (covered != 4'hF) begin
      while (cyc_no - last_clear < TIMEOUT) begin
        mid();
        chk("wait_gnt_ready", gnt_rdy, 1'b1);
        chk("wait_no_resp", resp_vld, 1'b0);
        nxt();
      end
    end
    flush = flush_resp && !killed;
    mid();
    if (killed) begin
      chk("drain_exit_ready", req_rdy, 1'b1);
      chk("drain_no_resp", resp_vld, 1'b0);
    end else begin
      chk("resp_valid", resp_vld, !flush_resp);
      chk("resp_err", resp_err, covered != 4'hF);
      chk("resp_paddr", resp_pa, pa);
      if (covered == 4'hF)
        chk("resp_data", resp_dat, {exp_line[3], exp_line[2], exp_line[1], exp_line[0]});
      chk("resp_gnt_ready", gnt_rdy, 1'b0);
      nxt();
      flush = 1'b0;
      mid();
      chk("post_resp_ready", req_rdy, 1'b1);
    end
    nxt();
    model_id = !model_id;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, nsend, fpos, aw, fa;
    int perm [4];
    int j, t;
    rstn = 1'b0;
    req_pa = '0;
    model_id = 1'b0;
    idle_in();
    @(posedge clk);
    #1;
    mid();
    chk_all_zero("reset");
    nxt();
    nxt();
    rstn = 1'b1;
    mid();
    chk("reset_exit_ready", req_rdy, 1'b1);
    chk("reset_exit_acq", acq_vld, 1'b0);
    chk("reset_exit_gnt", gnt_rdy, 1'b0);
    nxt();

    // In-order line, data 1..4
    plan.delete();
    for (int i = 0; i < 4; i++) add(1, i, 128'(i + 1), 1, 0);
    xact(26'h0ABCDE, 0, -1, 0);
    chk("t1_line", {exp_line[3], exp_line[2], exp_line[1], exp_line[0]},
        {128'h4, 128'h3, 128'h2, 128'h1});

    // Out of order with a duplicate of beat 2
    plan.delete();
    add(1, 2, rnd128(), 1, 0);
    add(1, 0, rnd128(), 1, 0);
    add(1, 3, rnd128(), 1, 0);
    add(1, 2, rnd128(), 1, 0);
    add(1, 1, rnd128(), 1, 0);
    xact(26'h1234567, 0, -1, 0);

    // Flush in GNT after two beats, remaining beats drained
    plan.delete();
    add(1, 0, rnd128(), 1, 0);
    add(1, 1, rnd128(), 1, 0);
    add(0, 0, '0, 1, 1);
    add(1, 2, rnd128(), 1, 0);
    add(1, 3, rnd128(), 1, 0);
    xact(26'h0000100, 0, -1, 0);

    // Acquire stalled five cycles with flush in the middle
    plan.delete();
    for (int i = 0; i < 4; i++) add(1, i, rnd128(), 1, 0);
    xact(26'h3FFFFFF, 5, 2, 0);

    // Hung L2, then an old-id straggler amid a normal line
    plan.delete();
    xact(26'h0055AA0, 0, -1, 0);
    plan.delete();
    add(1, 1, rnd128(), 0, 0);
    for (int i = 0; i < 4; i++) add(1, i, rnd128(), 1, 0);
    xact(26'h0055AA4, 1, -1, 0);

    // Request during flush is dropped
    idle_in();
    req_vld = 1'b1;
    flush   = 1'b1;
    req_pa  = 26'h0BADBAD;
    mid();
    chk("drop_req_ready", req_rdy, 1'b1);
    nxt();
    idle_in();
    mid();
    chk("drop_no_acq", acq_vld, 1'b0);
    chk("drop_still_idle", req_rdy, 1'b1);
    nxt();

    // Wrong-id beats amid valid beats, and a flushed response pulse
    plan.delete();
    add(1, 0, rnd128(), 1, 0);
    add(1, 1, rnd128(), 0, 0);
    add(1, 1, rnd128(), 1, 0);
    add(1, 2, rnd128(), 1, 0);
    add(1, 3, rnd128(), 0, 0);
    add(1, 3, rnd128(), 1, 0);
    xact(26'h0C0FFEE, 0, -1, 0);
    plan.delete();
    for (int i = 0; i < 4; i++) add(1, 3 - i, rnd128(), 1, 0);
    xact(26'h0C0FFF0, 2, -1, 1);

    // Reset in the middle of GNT
    idle_in();
    req_vld = 1'b1;
    req_pa  = 26'h0777777;
    nxt();
    req_vld = 1'b0;
    acq_rdy = 1'b1;
    nxt();
    idle_in();
    gnt_vld = 1'b1;
    gnt_id  = model_id;
    gnt_dat = rnd128();
    nxt();
    gnt_beat = 2'd1;
    nxt();
    idle_in();
    rstn = 1'b0;
    mid();
    chk_all_zero("midgnt_reset");
    nxt();
    rstn = 1'b1;
    model_id = 1'b0;
    mid();
    chk("midgnt_reset_ready", req_rdy, 1'b1);
    chk("midgnt_reset_gnt", gnt_rdy, 1'b0);
    nxt();

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      perm = '{0, 1, 2, 3};
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      nsend = (mode == 3) ? $urandom_range(0, 3) : 4;
      fpos  = (mode == 1) ? $urandom_range(0, 2) : -1;
      plan.delete();
      for (int i = 0; i < nsend; i++) begin
        if ($urandom_range(0, 3) == 0) add(0, 0, '0, 1, 0);
        if ($urandom_range(0, 3) == 0) add(1, $urandom_range(0, 3), rnd128(), 0, 0);
        if (i > 0 && $urandom_range(0, 3) == 0) add(1, perm[$urandom_range(0, i - 1)], rnd128(), 1, 0);
        add(1, perm[i], rnd128(), 1, i == fpos);
      end
      if (mode == 3 && $urandom_range(0, 1) == 1) add(1, $urandom_range(0, 3), rnd128(), 0, 0);
      aw = $urandom_range(0, 3);
      fa = (mode == 2 || (mode == 3 && $urandom_range(0, 2) == 0)) ? $urandom_range(0, aw) : -1;
      xact(ADDR_W'($urandom), aw, fa, mode == 0 && $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
